// File: rtl/ram_pkg.sv
// ram_pkg
// Shared definitions for the byte-write-enable dual-port RAM:
//   - ram_state_e : clear-sequencer states (INIT, READY)
//   - RDW_OLD / RDW_NEW : same-address read-during-write selections
//   - lane_merge() : replaces the byte lanes of a word selected by a
//                    byte-enable vector
package ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // The merge function works on fixed-size containers so a single
  // definition serves every instance width. Callers widen their operands
  // with a size cast and truncate the result the same way.
  localparam int MERGE_MAX_W     = 256;
  localparam int MERGE_MAX_LANES = 256;

  // Bit i of the result comes from new_word when the lane holding bit i
  // is enabled, otherwise from old_word. byte_width is a constant at every
  // call site, so the division folds away in synthesis.
  function automatic logic [MERGE_MAX_W-1:0] lane_merge(
    input logic [MERGE_MAX_W-1:0]     old_word,
    input logic [MERGE_MAX_W-1:0]     new_word,
    input logic [MERGE_MAX_LANES-1:0] be,
    input int                         byte_width
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_MAX_W; i++) begin
      if (be[8'(i / byte_width)]) begin
        merged[8'(i)] = new_word[8'(i)];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// ram_init_seq
// Clear sequencer for the RAM array. After reset release it walks every
// address once, one per cycle, requesting a zero write, then parks in
// READY until the next reset.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   init_busy  out  high while the clear walk runs (registered)
//   clr_addr   out  address to clear this cycle
//   clr_we     out  clear write strobe
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_INIT  | zeroing address clr_addr this cycle; user ports ignored
// ST_READY | clear finished; RAM serves user reads and writes
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_we
);

  ram_state_e            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          // The counter wraps back to zero on the last address, so it
          // is already at its reset value when READY is entered.
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state     <= ST_READY;
            init_busy <= 1'b0;
          end
        end
        ST_READY: begin
          init_busy <= 1'b0;
        end
        default: begin
          state     <= ST_INIT;
          clr_cnt   <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  assign clr_addr = clr_cnt;
  assign clr_we   = init_busy;

endmodule

// File: rtl/bwe_dual_port_ram.sv
// bwe_dual_port_ram
// Simple dual-port RAM (one write port, one read port, single clock) with
// per-byte write enables, a configurable 1- or 2-cycle registered read and
// a selectable same-address read-during-write result. The array is zeroed
// by a clear sequence after every reset; user traffic is dropped while
// that sequence runs.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   init_busy  out  high while the clear sequence runs
//   wr_en      in   write request
//   wr_addr    in   write address
//   wr_be      in   per-byte-lane write enable
//   wr_data    in   write data
//   rd_en      in   read request
//   rd_addr    in   read address
//   rd_data    out  registered read data, holds between reads
//   rd_valid   out  one-cycle pulse qualifying rd_data
module bwe_dual_port_ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int BYTE_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             init_busy,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid
);

  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  if (BYTE_WIDTH < 1 || (DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_byte_width
    $error("bwe_dual_port_ram: DATA_WIDTH must be a non-zero multiple of BYTE_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("bwe_dual_port_ram: RD_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
    $error("bwe_dual_port_ram: RDW_MODE must be RDW_OLD or RDW_NEW");
  end
  if (DATA_WIDTH > MERGE_MAX_W) begin : g_too_wide
    $error("bwe_dual_port_ram: DATA_WIDTH exceeds the lane_merge container");
  end

  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_we;

  ram_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (init_busy),
    .clr_addr  (clr_addr),
    .clr_we    (clr_we)
  );

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_fire;
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word;

  // An all-zero byte enable would rewrite the old word unchanged; skipping
  // it keeps the array quiet.
  assign wr_fire = wr_en & ~init_busy & (|wr_be);
  assign rd_fire = rd_en & ~init_busy;

  assign wr_merged = DATA_WIDTH'(lane_merge(MERGE_MAX_W'(mem[wr_addr]),
                                            MERGE_MAX_W'(wr_data),
                                            MERGE_MAX_LANES'(wr_be),
                                            BYTE_WIDTH));

  // The array has no reset; only the clear walk initialises it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  // Old-data mode needs no bypass: the array is read before the write of
  // the same edge lands. New-data mode forwards the merged write word.
  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_MODE == RDW_NEW && wr_fire && (wr_addr == rd_addr)) begin
      rd_word = wr_merged;
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_fire;
        if (rd_fire) begin
          rd_data <= rd_word;
        end
      end
    end
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_data  <= '0;
        s1_valid <= 1'b0;
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        s1_valid <= rd_fire;
        if (rd_fire) begin
          s1_data <= rd_word;
        end
        rd_valid <= s1_valid;
        if (s1_valid) begin
          rd_data <= s1_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_bwe_dual_port_ram.sv
// Testbench for bwe_dual_port_ram. Two instances share one stimulus
// stream: dut_a (1-cycle read, old data on collision) and dut_b (2-cycle
// read, new data on collision). A word-level model tracks the array
// contents and the read results each instance owes, and a compare process
// checks every output of both instances on every falling edge.
module tb_bwe_dual_port_ram;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NB    = 4;
  localparam int DEPTH = 16;
  localparam int LAT_A = 1;
  localparam int LAT_B = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NB-1:0] wr_be;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic          a_busy, b_busy, a_valid, b_valid;
  logic [DW-1:0] a_data, b_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bwe_dual_port_ram #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .BYTE_WIDTH (8),
    .RD_LATENCY (LAT_A), .RDW_MODE (0)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .init_busy (a_busy),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_be (wr_be), .wr_data (wr_data),
    .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (a_data), .rd_valid (a_valid)
  );

  bwe_dual_port_ram #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .BYTE_WIDTH (8),
    .RD_LATENCY (LAT_B), .RDW_MODE (1)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .init_busy (b_busy),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_be (wr_be), .wr_data (wr_data),
    .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (b_data), .rd_valid (b_valid)
  );

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cmp1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_item_t;

  rd_item_t      q_a[$];
  rd_item_t      q_b[$];
  logic [DW-1:0] m_mem [DEPTH];
  int            cyc       = 0;
  int            init_left = DEPTH;
  logic [DW-1:0] exp_data_a = '0, exp_data_b = '0;
  logic          exp_valid_a = 1'b0, exp_valid_b = 1'b0, exp_busy = 1'b1;
  logic [DW-1:0] m_old, m_merged;

  function automatic logic [DW-1:0] apply_be(input logic [DW-1:0] old_w,
                                             input logic [DW-1:0] new_w,
                                             input logic [NB-1:0] be);
    logic [DW-1:0] w;
    w = old_w;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) w[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return w;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        q_a.delete();
        q_b.delete();
        exp_data_a  = '0;
        exp_data_b  = '0;
        exp_valid_a = 1'b0;
        exp_valid_b = 1'b0;
        exp_busy    = 1'b1;
        init_left   = DEPTH;
      end else begin
        if (init_left > 0) begin
          m_mem[DEPTH - init_left] = '0;
          init_left--;
        end else begin
          m_old    = m_mem[rd_addr];
          m_merged = apply_be(m_mem[wr_addr], wr_data, wr_be);
          if (rd_en) begin
            q_a.push_back('{cyc + LAT_A - 1, m_old});
            q_b.push_back('{cyc + LAT_B - 1,
                            (wr_en && wr_addr == rd_addr) ? m_merged : m_old});
          end
          if (wr_en) m_mem[wr_addr] = m_merged;
        end
        exp_busy    = (init_left > 0);
        exp_valid_a = 1'b0;
        exp_valid_b = 1'b0;
        if (q_a.size() > 0 && q_a[0].due == cyc) begin
          exp_valid_a = 1'b1;
          exp_data_a  = q_a[0].data;
          void'(q_a.pop_front());
        end
        if (q_b.size() > 0 && q_b[0].due == cyc) begin
          exp_valid_b = 1'b1;
          exp_data_b  = q_b[0].data;
          void'(q_b.pop_front());
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      cmp1("a_busy",  a_busy,  exp_busy);
      cmp1("b_busy",  b_busy,  exp_busy);
      cmp1("a_valid", a_valid, exp_valid_a);
      cmp1("b_valid", b_valid, exp_valid_b);
      cmp ("a_data",  a_data,  exp_data_a);
      cmp ("b_data",  b_data,  exp_data_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic read(input logic [AW-1:0] a);
    rd_en = 1'b1; rd_addr = a;
  endtask

  // Releases reset with rd_en held high and sweeps reads over every
  // address once the clear sequence finishes.
  task automatic release_and_sweep(input string tag);
    int busy_cycles, valid_in_busy, k;
    busy_cycles = 0; valid_in_busy = 0; k = 0;
    idle();
    rd_en = 1'b1;
    rst_n = 1'b1;
    for (int it = 0; it < 64 && k < DEPTH; it++) begin
      if (a_busy) begin
        busy_cycles++;
        if (a_valid || b_valid) valid_in_busy++;
        rd_addr = '0;
      end else begin
        rd_addr = AW'(k);
        k++;
      end
      tick();
    end
    idle();
    cmp({tag, "_busy_cycles"}, DW'(busy_cycles), 32'd16);
    cmp({tag, "_valid_in_busy"}, DW'(valid_in_busy), 32'd0);
    cmp({tag, "_sweep_reads"}, DW'(k), 32'd16);
    tick();
    tick();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    rd_en = 1'b1;
    repeat (3) tick();
    cmp1("rst_a_busy",  a_busy,  1'b1);
    cmp1("rst_a_valid", a_valid, 1'b0);
    cmp ("rst_a_data",  a_data,  32'h0);
    cmp ("rst_b_data",  b_data,  32'h0);

    release_and_sweep("init");

    // byte-lane merge on one address
    write(4'd3, 32'hA5A5A5A5, 4'hF); tick();
    write(4'd3, 32'h11223344, 4'h5); tick();
    idle(); read(4'd3); tick();
    cmp1("merge_a_valid", a_valid, 1'b1);
    cmp ("merge_a_data",  a_data,  32'hA522A544);
    idle(); tick();
    cmp ("merge_b_data",  b_data,  32'hA522A544);
    cmp1("merge_a_pulse", a_valid, 1'b0);
    cmp ("model_m3",      m_mem[3], 32'hA522A544);

    // back-to-back reads through the 2-cycle port
    write(4'd4, 32'h44444444, 4'hF); tick();
    write(4'd5, 32'h55555555, 4'hF); tick();
    idle(); read(4'd3); tick();
    cmp1("b2b_b_valid_p1", b_valid, 1'b0);
    read(4'd4); tick();
    cmp1("b2b_b_valid_p2", b_valid, 1'b1);
    cmp ("b2b_b_data_p2",  b_data,  32'hA522A544);
    read(4'd5); tick();
    cmp ("b2b_b_data_p3",  b_data,  32'h44444444);
    idle(); tick();
    cmp ("b2b_b_data_p4",  b_data,  32'h55555555);
    tick();
    cmp1("b2b_b_valid_end", b_valid, 1'b0);
    cmp ("b2b_b_hold",      b_data,  32'h55555555);

    // same-address read during write
    write(4'd7, 32'hDEADBEEF, 4'hF); read(4'd7); tick();
    cmp ("rdw_old_a", a_data, 32'h00000000);
    idle(); tick();
    cmp ("rdw_new_b", b_data, 32'hDEADBEEF);
    cmp ("model_m7",  m_mem[7], 32'hDEADBEEF);

    // all-zero byte enable
    write(4'd2, 32'h12345678, 4'hF); tick();
    write(4'd2, 32'hFFFFFFFF, 4'h0); tick();
    idle(); read(4'd2); tick();
    cmp ("be0_a", a_data, 32'h12345678);
    idle(); tick();
    cmp ("be0_b", b_data, 32'h12345678);
    cmp ("model_m2", m_mem[2], 32'h12345678);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      wr_en   = ($urandom_range(0, 2) != 0);
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_be   = NB'($urandom_range(0, 15));
      wr_data = $urandom();
      rd_en   = ($urandom_range(0, 1) != 0);
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      tick();
    end
    idle();
    repeat (3) tick();

    // reset mid-operation, then again partway through the clear
    write(4'd9, 32'hCAFEF00D, 4'hF); tick();
    idle(); read(4'd9); tick();
    idle(); tick();
    cmp ("pre_rst_a_data", a_data, 32'hCAFEF00D);
    cmp ("pre_rst_b_data", b_data, 32'hCAFEF00D);
    #1 rst_n = 1'b0;
    #1;
    cmp ("async_rst_a_data",  a_data,  32'h0);
    cmp ("async_rst_b_data",  b_data,  32'h0);
    cmp1("async_rst_a_valid", a_valid, 1'b0);
    cmp1("async_rst_b_valid", b_valid, 1'b0);
    cmp1("async_rst_busy",    a_busy,  1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    #1 rst_n = 1'b0;
    #1;
    cmp1("rst_in_init_busy", b_busy, 1'b1);
    tick();
    tick();
    release_and_sweep("reinit");
    cmp ("model_m9_cleared", m_mem[9], 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
